// File: rtl/button_event_ctrl.sv
// Multi-button front end: 2-flop sync, debounce, press/release/long-press detection,
// round-robin event scheduling into a first-word-fallthrough event FIFO.
module button_event_ctrl #(
    parameter int NUM_BUTTONS      = 4,
    parameter int DEBOUNCE_LIMIT   = 20,
    parameter int LONG_PRESS_LIMIT = 1000,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_BUTTONS-1:0]         btn_in,
    output logic [NUM_BUTTONS-1:0]         btn_state,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [$clog2(NUM_BUTTONS)-1:0] evt_id,
    output logic [1:0]                     evt_type,
    output logic                           overflow,
    input  logic                           clr_overflow
);

    localparam int ID_W   = $clog2(NUM_BUTTONS);
    localparam int DB_W   = $clog2(DEBOUNCE_LIMIT);
    localparam int HOLD_W = $clog2(LONG_PRESS_LIMIT + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_LONG    = 2'b10
    } evt_type_e;

    logic [NUM_BUTTONS-1:0] sync_q1;
    logic [NUM_BUTTONS-1:0] sync_s;
    logic [DB_W-1:0]        db_cnt   [NUM_BUTTONS];
    logic [HOLD_W-1:0]      hold_cnt [NUM_BUTTONS];

    logic [NUM_BUTTONS-1:0] db_flip;
    logic [NUM_BUTTONS-1:0] new_evt;
    evt_type_e              new_type [NUM_BUTTONS];

    logic [NUM_BUTTONS-1:0] pend_valid;
    evt_type_e              pend_type [NUM_BUTTONS];

    logic                   grant_valid;
    logic [ID_W-1:0]        grant_idx;
    logic [NUM_BUTTONS-1:0] grant_mask;
    logic [ID_W-1:0]        rr_ptr;
    logic                   drop_any;

    logic [ID_W-1:0]        fifo_id   [FIFO_DEPTH];
    evt_type_e              fifo_type [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_cnt;
    logic                   push;
    logic                   pop;

    // Flip on the DEBOUNCE_LIMIT-th consecutive differing sample; a release that
    // coincides with the long-press threshold reports the RELEASE only.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        db_flip = '0;
        new_evt = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            new_type[i] = EVT_PRESS;
            db_flip[i]  = (sync_s[i] != btn_state[i]) &&
                          (db_cnt[i] == DB_W'(DEBOUNCE_LIMIT - 1));
            if (db_flip[i]) begin
                new_evt[i]  = 1'b1;
                new_type[i] = btn_state[i] ? EVT_RELEASE : EVT_PRESS;
            end else if (btn_state[i] && hold_cnt[i] == HOLD_W'(LONG_PRESS_LIMIT - 1)) begin
                new_evt[i]  = 1'b1;
                new_type[i] = EVT_LONG;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= '0;
            sync_s    <= '0;
            btn_state <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            sync_q1 <= btn_in;
            sync_s  <= sync_q1;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (sync_s[i] == btn_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] < DB_W'(DEBOUNCE_LIMIT - 1)) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end else begin
                    btn_state[i] <= sync_s[i];
                    db_cnt[i]    <= '0;
                end
                if (!btn_state[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != HOLD_W'(LONG_PRESS_LIMIT)) begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Round-robin search from rr_ptr upward; a full FIFO blocks grants even if popped this edge.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (fifo_cnt != CNT_W'(FIFO_DEPTH)) begin
            for (int k = 0; k < NUM_BUTTONS; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_BUTTONS) idx = idx - NUM_BUTTONS;
                if (!grant_valid && pend_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = ID_W'(idx);
                end
            end
        end
    end

    assign grant_mask = grant_valid ? (NUM_BUTTONS'(1) << grant_idx) : '0;
    assign drop_any   = |(new_evt & pend_valid & ~grant_mask);
    assign push       = grant_valid;
    assign pop        = evt_valid && evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= '0;
            rr_ptr     <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < NUM_BUTTONS; i++) pend_type[i] <= EVT_PRESS;
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (new_evt[i]) begin
                    if (!pend_valid[i] || grant_mask[i]) begin
                        pend_valid[i] <= 1'b1;
                        pend_type[i]  <= new_type[i];
                    end
                end else if (grant_mask[i]) begin
                    pend_valid[i] <= 1'b0;
                end
            end
            if (grant_valid) begin
                rr_ptr <= (grant_idx == ID_W'(NUM_BUTTONS - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (drop_any) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: FIFO storage is left unreset; only pointers/count are reset and the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]   <= grant_idx;
            fifo_type[wr_ptr] <= pend_type[grant_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign evt_valid = (fifo_cnt != '0);
    assign evt_id    = evt_valid ? fifo_id[rd_ptr] : '0;
    assign evt_type  = evt_valid ? fifo_type[rd_ptr] : EVT_PRESS;

endmodule
